// File: rtl/boot_block_loader_if.sv
// SD block-read and memory line-write handshakes of the boot block loader.
// The loader side uses the master modport; SD controller and memory use slave.
interface boot_block_loader_if #(
  parameter int LINE_AW = 16
) ();
  logic               sd_req;
  logic [31:0]        sd_block;
  logic               sd_ack;
  logic               sd_data_valid;
  logic [63:0]        sd_data;
  logic               sd_data_ready;
  logic               sd_err;
  logic               mem_wr_valid;
  logic               mem_wr_ready;
  logic [LINE_AW-1:0] mem_wr_addr;
  logic [511:0]       mem_wr_data;

  modport master (
    output sd_req, sd_block, sd_data_ready, mem_wr_valid, mem_wr_addr, mem_wr_data,
    input  sd_ack, sd_data_valid, sd_data, sd_err, mem_wr_ready
  );

  modport slave (
    input  sd_req, sd_block, sd_data_ready, mem_wr_valid, mem_wr_addr, mem_wr_data,
    output sd_ack, sd_data_valid, sd_data, sd_err, mem_wr_ready
  );
endinterface

// File: rtl/boot_block_loader.sv
// Boot-time loader: copies disk blocks of two channels from the SD controller
// into 512-bit memory lines, then releases the CPUs (or holds them on SD error).
module boot_block_loader #(
  parameter int BLOCK_BEATS = 64,
  parameter int LINE_AW     = 16,
  parameter int SWAP        = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        block_addr_0,
  input  logic [31:0]        block_count_0,
  input  logic [LINE_AW-1:0] dest_line_0,
  input  logic [31:0]        block_addr_1,
  input  logic [31:0]        block_count_1,
  input  logic [LINE_AW-1:0] dest_line_1,
  boot_block_loader_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               cpu_release
);

  localparam int BCW = $clog2(BLOCK_BEATS + 1);
  localparam logic [BCW-1:0] BEATS_INIT = BCW'(BLOCK_BEATS);

  typedef enum logic [2:0] {IDLE, REQ, DATA, FLUSH, NEXT, DONE, ERR} state_t;

  state_t             state_q, state_d;
  logic               start_q, start_d;
  logic               start_prev_q, start_prev_d;
  logic               chan_q, chan_d;
  logic [31:0]        blk_addr_q, blk_addr_d;
  logic [31:0]        remaining_q, remaining_d;
  logic [LINE_AW-1:0] line_q, line_d;
  logic [BCW-1:0]     beats_left_q, beats_left_d;
  logic [2:0]         slot_q, slot_d;
  logic               line_full_q, line_full_d;
  logic [511:0]       line_buf_q, line_buf_d;
  logic               err_pend_q, err_pend_d;
  logic [31:0]        addr1_q, addr1_d;
  logic [31:0]        cnt1_q, cnt1_d;
  logic [LINE_AW-1:0] dest1_q, dest1_d;

  logic        sd_req_c, sd_data_ready_c, mem_wr_valid_c;
  logic        start_edge, err_seen;
  logic [63:0] beat_in;

  function automatic logic [63:0] swap_bytes(input logic [63:0] b);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*(7-i) +: 8] = b[8*i +: 8];
    return r;
  endfunction

  assign beat_in    = (SWAP != 0) ? swap_bytes(bus.sd_data) : bus.sd_data;
  // start comes from a GPIO pin, so the edge is taken from two registered samples
  assign start_edge = start_q && !start_prev_q;
  assign err_seen   = bus.sd_err || err_pend_q;

  always_comb begin
    state_d         = state_q;
    start_d         = start;
    start_prev_d    = start_q;
    chan_d          = chan_q;
    blk_addr_d      = blk_addr_q;
    remaining_d     = remaining_q;
    line_d          = line_q;
    beats_left_d    = beats_left_q;
    slot_d          = slot_q;
    line_full_d     = line_full_q;
    line_buf_d      = line_buf_q;
    err_pend_d      = err_pend_q;
    addr1_d         = addr1_q;
    cnt1_d          = cnt1_q;
    dest1_d         = dest1_q;
    sd_req_c        = 1'b0;
    sd_data_ready_c = 1'b0;
    mem_wr_valid_c  = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    error           = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          addr1_d = block_addr_1;
          cnt1_d  = block_count_1;
          dest1_d = dest_line_1;
          if (block_count_0 != 32'd0) begin
            chan_d      = 1'b0;
            blk_addr_d  = block_addr_0;
            remaining_d = block_count_0;
            line_d      = dest_line_0;
            state_d     = REQ;
          end else if (block_count_1 != 32'd0) begin
            chan_d      = 1'b1;
            blk_addr_d  = block_addr_1;
            remaining_d = block_count_1;
            line_d      = dest_line_1;
            state_d     = REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      REQ: begin
        busy = 1'b1;
        if (err_seen) begin
          state_d = ERR;
        end else begin
          sd_req_c = 1'b1;
          if (bus.sd_ack) begin
            beats_left_d = BEATS_INIT;
            slot_d       = 3'd0;
            state_d      = DATA;
          end
        end
      end
      DATA: begin
        busy            = 1'b1;
        sd_data_ready_c = !line_full_q && !err_pend_q;
        if (err_seen) begin
          state_d = ERR;
        end else if (bus.sd_data_valid && sd_data_ready_c) begin
          line_buf_d[{slot_q, 6'd0} +: 64] = beat_in;
          slot_d       = slot_q + 3'd1;
          beats_left_d = beats_left_q - BCW'(1);
          if (slot_q == 3'd7) begin
            line_full_d = 1'b1;
            state_d     = FLUSH;
          end
        end
      end
      FLUSH: begin
        busy           = 1'b1;
        mem_wr_valid_c = 1'b1;
        // an error here must not cancel the write already on the bus
        if (bus.sd_err) err_pend_d = 1'b1;
        if (bus.mem_wr_ready) begin
          line_full_d = 1'b0;
          line_d      = line_q + LINE_AW'(1);
          state_d     = (beats_left_q == '0) ? NEXT : DATA;
        end
      end
      NEXT: begin
        busy        = 1'b1;
        blk_addr_d  = blk_addr_q + 32'd1;
        remaining_d = remaining_q - 32'd1;
        if (remaining_q != 32'd1) begin
          state_d = REQ;
        end else if (!chan_q && cnt1_q != 32'd0) begin
          chan_d      = 1'b1;
          blk_addr_d  = addr1_q;
          remaining_d = cnt1_q;
          line_d      = dest1_q;
          state_d     = REQ;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    done  = 1'b1;
      ERR:     error = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  assign cpu_release       = done;
  assign bus.sd_req        = sd_req_c;
  assign bus.sd_block      = blk_addr_q;
  assign bus.sd_data_ready = sd_data_ready_c;
  assign bus.mem_wr_valid  = mem_wr_valid_c;
  assign bus.mem_wr_addr   = line_q;
  assign bus.mem_wr_data   = line_buf_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      chan_q       <= 1'b0;
      blk_addr_q   <= '0;
      remaining_q  <= '0;
      line_q       <= '0;
      beats_left_q <= '0;
      slot_q       <= '0;
      line_full_q  <= 1'b0;
      line_buf_q   <= '0;
      err_pend_q   <= 1'b0;
      addr1_q      <= '0;
      cnt1_q       <= '0;
      dest1_q      <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      start_prev_q <= start_prev_d;
      chan_q       <= chan_d;
      blk_addr_q   <= blk_addr_d;
      remaining_q  <= remaining_d;
      line_q       <= line_d;
      beats_left_q <= beats_left_d;
      slot_q       <= slot_d;
      line_full_q  <= line_full_d;
      line_buf_q   <= line_buf_d;
      err_pend_q   <= err_pend_d;
      addr1_q      <= addr1_d;
      cnt1_q       <= cnt1_d;
      dest1_q      <= dest1_d;
    end
  end

endmodule

// File: tb/tb_boot_block_loader.sv
// Bench for boot_block_loader: random SD/memory responders, expected block list
// and memory image computed from the channel descriptors.
module tb_boot_block_loader;
  localparam int BB  = 64;
  localparam int AW  = 16;
  localparam int LPB = BB / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   cnt0 = '0, addr0 = '0, cnt1 = '0, addr1 = '0;
  logic [AW-1:0] dst0 = '0, dst1 = '0;
  logic          busy, done, error, cpu_release;

  boot_block_loader_if #(.LINE_AW(AW)) bus ();

  boot_block_loader #(.BLOCK_BEATS(BB), .LINE_AW(AW), .SWAP(1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .block_addr_0(addr0), .block_count_0(cnt0), .dest_line_0(dst0),
    .block_addr_1(addr1), .block_count_1(cnt1), .dest_line_1(dst1),
    .bus(bus), .busy(busy), .done(done), .error(error), .cpu_release(cpu_release)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0]   salt = '0;
  int            err_beat_cfg = -1;
  int            stall_line = -1, stall_left = 0;
  bit            stall_done = 0, mem_hold = 0, mem_rand = 0;
  logic [31:0]   exp_blk[$], got_blk[$];
  logic [AW-1:0] exp_addr[$], got_addr[$];
  logic [511:0]  exp_data[$], got_data[$];

  function automatic logic [63:0] beat_val(input logic [31:0] blk, input int k);
    return {blk ^ salt, salt[31:16], 16'(k)};
  endfunction

  // SD delivers byte 0 in bits [7:0]; memory wants byte 0 in the top byte of each beat
  function automatic logic [511:0] line_val(input logic [31:0] blk, input int ln);
    logic [511:0] r;
    logic [63:0]  b, s;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      b = beat_val(blk, ln * 8 + j);
      s = {<<8{b}};
      r[64*j +: 64] = s;
    end
    return r;
  endfunction

  task automatic build_expect(input int eb);
    logic [31:0]   c, a;
    logic [AW-1:0] la;
    exp_blk.delete(); exp_addr.delete(); exp_data.delete();
    for (int ch = 0; ch < 2; ch++) begin
      c  = ch ? cnt1 : cnt0;
      a  = ch ? addr1 : addr0;
      la = ch ? dst1 : dst0;
      for (int b = 0; b < int'(c); b++) begin
        exp_blk.push_back(a + 32'(b));
        for (int l = 0; l < LPB; l++) begin
          if (eb >= 0 && l * 8 + 7 >= eb) return;
          exp_addr.push_back(la);
          exp_data.push_back(line_val(a + 32'(b), l));
          la = la + AW'(1);
        end
        if (eb >= 0) return;
      end
    end
  endtask

  // SD controller model: acks requests, streams beats with random gaps
  int          sd_phase = 0, beat_idx = 0;
  logic [31:0] cur_blk = '0;
  initial begin
    bus.sd_ack = 0; bus.sd_data_valid = 0; bus.sd_data = '0; bus.sd_err = 0;
    forever begin
      @(negedge clk);
      bus.sd_ack = 0;
      bus.sd_err = 0;
      if (!reset) begin
        sd_phase = 0;
        bus.sd_data_valid = 0;
      end else if (sd_phase == 0) begin
        bus.sd_data_valid = 0;
        if (bus.sd_req && $urandom_range(0, 2) != 0) begin
          bus.sd_ack = 1;
          cur_blk = bus.sd_block;
          got_blk.push_back(bus.sd_block);
          sd_phase = 1;
          beat_idx = 0;
        end
      end else if (sd_phase == 1) begin
        bus.sd_data = beat_val(cur_blk, beat_idx);
        if (err_beat_cfg >= 0 && got_blk.size() == 1 && beat_idx == err_beat_cfg) begin
          bus.sd_err = 1;
          bus.sd_data_valid = 1;
          sd_phase = 2;
        end else begin
          bus.sd_data_valid = ($urandom_range(0, 3) != 0);
          if (bus.sd_data_valid && bus.sd_data_ready) begin
            beat_idx++;
            if (beat_idx == BB) sd_phase = 0;
          end
        end
      end else begin
        bus.sd_data_valid = 0;
      end
    end
  end

  // memory model: random or stalled ready, records every accepted line write
  initial begin
    bus.mem_wr_ready = 0;
    forever begin
      @(negedge clk);
      if (!reset || mem_hold) begin
        bus.mem_wr_ready = 0;
      end else if (stall_left > 0) begin
        bus.mem_wr_ready = 0;
        stall_left--;
        chk("stall_sd_ready", 512'(bus.sd_data_ready), 512'(0));
      end else if (stall_line >= 0 && !stall_done && bus.mem_wr_valid &&
                   got_addr.size() == stall_line) begin
        stall_done = 1;
        stall_left = 19;
        bus.mem_wr_ready = 0;
      end else begin
        bus.mem_wr_ready = mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (reset && bus.mem_wr_valid && bus.mem_wr_ready) begin
        got_addr.push_back(bus.mem_wr_addr);
        got_data.push_back(bus.mem_wr_data);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_flags"}, 512'({busy, done, error, cpu_release, bus.sd_req,
                              bus.sd_data_ready, bus.mem_wr_valid}), 512'(0));
    chk({nm, "_addr"}, 512'({bus.sd_block, bus.mem_wr_addr}), 512'(0));
    chk({nm, "_data"}, bus.mem_wr_data, 512'(0));
  endtask

  task automatic do_reset();
    reset = 0;
    start = 0;
    cyc(3);
    check_all_zero("rst");
    reset = 1;
  endtask

  task automatic go(input string nm, input int eb);
    int   t;
    logic seen;
    got_blk.delete(); got_addr.delete(); got_data.delete();
    err_beat_cfg = eb;
    stall_done = 0;
    stall_left = 0;
    build_expect(eb);
    cyc(2);
    start = 1;
    t = 0;
    while (!(done || error) && t < 20000) begin
      cyc(1);
      t++;
    end
    chk({nm, "_timeout"}, 512'(t < 20000), 512'(1));
    start = 0;
    chk({nm, "_done"}, 512'({done, cpu_release}), 512'(eb < 0 ? 2'b11 : 2'b00));
    chk({nm, "_error"}, 512'(error), 512'(eb >= 0));
    seen = 0;
    repeat (20) begin
      cyc(1);
      seen |= bus.sd_req | bus.mem_wr_valid | busy;
    end
    chk({nm, "_quiet"}, 512'(seen), 512'(0));
    chk({nm, "_nreq"}, 512'(got_blk.size()), 512'(exp_blk.size()));
    chk({nm, "_nwr"}, 512'(got_addr.size()), 512'(exp_addr.size()));
    for (int i = 0; i < got_blk.size() && i < exp_blk.size(); i++)
      chk({nm, "_blk"}, 512'(got_blk[i]), 512'(exp_blk[i]));
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      chk({nm, "_waddr"}, 512'(got_addr[i]), 512'(exp_addr[i]));
      chk({nm, "_wdata"}, got_data[i], exp_data[i]);
    end
  endtask

  task automatic run(input string nm, input logic [31:0] c0, input logic [31:0] a0,
                     input logic [AW-1:0] d0, input logic [31:0] c1, input logic [31:0] a1,
                     input logic [AW-1:0] d1, input int eb, input int stl);
    do_reset();
    cnt0 = c0; addr0 = a0; dst0 = d0;
    cnt1 = c1; addr1 = a1; dst1 = d1;
    stall_line = stl;
    go(nm, eb);
  endtask

  initial begin
    int t;
    salt = '0;
    mem_rand = 0;
    run("single", 32'd1, 32'd5, 16'h0100, 32'd0, 32'd0, 16'h0000, -1, -1);

    salt = $urandom;
    run("two_ch", 32'd2, 32'd0, 16'(AW'($urandom)), 32'd1, 32'h40, 16'h2000, -1, -1);

    run("stall", 32'd2, 32'd7, 16'h0300, 32'd0, 32'd0, 16'h0000, -1, 3);

    mem_rand = 1;
    run("err", 32'd2, 32'd9, 16'h0010, 32'd1, 32'h50, 16'h0020, 30, -1);

    // both counts zero: done two cycles after start is raised, no SD traffic
    do_reset();
    cnt0 = '0; cnt1 = '0;
    got_blk.delete();
    cyc(2);
    start = 1;
    cyc(1);
    chk("zero_done_early", 512'(done), 512'(0));
    cyc(1);
    chk("zero_done", 512'({done, cpu_release, busy}), 512'(3'b110));
    chk("zero_nreq", 512'(got_blk.size()), 512'(0));
    start = 0;

    run("wrap", 32'd1, 32'h33, 16'hFFFF, 32'd0, 32'd0, 16'h0000, -1, -1);

    for (int r = 0; r < 3; r++) begin
      salt = $urandom;
      run("rand", 32'($urandom_range(0, 2)), $urandom, 16'(AW'($urandom)),
          32'($urandom_range(0, 2)), $urandom, 16'(AW'($urandom)), -1, -1);
    end

    // reset while a line write is pending, then restart without another reset
    salt = $urandom;
    do_reset();
    cnt0 = 32'd2; addr0 = 32'h1234; dst0 = 16'h0400;
    cnt1 = 32'd1; addr1 = 32'h77;   dst1 = 16'h0800;
    stall_line = -1;
    err_beat_cfg = -1;
    mem_hold = 1;
    cyc(2);
    start = 1;
    t = 0;
    while (!bus.mem_wr_valid && t < 5000) begin
      cyc(1);
      t++;
    end
    chk("rstmid_flush_seen", 512'(t < 5000), 512'(1));
    reset = 0;
    start = 0;
    cyc(1);
    check_all_zero("rstmid");
    cyc(1);
    mem_hold = 0;
    reset = 1;
    go("restart", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
